// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the single-issue 32-bit core. Owns the program counter,
// presents it combinationally to InstructionMemory, and captures the returned
// word into the IF/ID pipeline register for decode. Decode stalls freeze the
// stage. Downstream redirects (taken branch / resolved jump) reload the PC and
// flush IF/ID to a NOP bubble.
//
// Parameters
//   RESET_PC     PC loaded on reset (low two bits are forced to zero)
//   COUNT_WIDTH  width of the fetched-instruction counter
//
// Ports
//   clk              rising-edge clock
//   reset_n          synchronous active-low reset
//   stall            hold PC and IF/ID for this cycle
//   redirect         load redirect_target into the PC, flush IF/ID
//   redirect_target  new PC (bits [1:0] ignored)
//   instr_data       instruction word at 'address' (combinational memory)
//   address          current PC, to InstructionMemory
//   if_id_instr      registered instruction for decode
//   if_id_pc_plus4   registered PC+4 of that instruction
//   if_id_valid      if_id_instr holds a real fetched instruction
//   fetch_count      instructions accepted into IF/ID (wraps)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_target,
  input  logic [31:0]            instr_data,
  output logic [31:0]            address,
  output logic [31:0]            if_id_instr,
  output logic [31:0]            if_id_pc_plus4,
  output logic                   if_id_valid,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  // Per-cycle behaviour of the stage. This is not a state machine: the mode
  // is decided purely from the current cycle's inputs.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_HOLD  = 2'd1,
    MODE_FLUSH = 2'd2
  } mode_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  mode_t                  mode;
  logic [31:0]            pc_reg, pc_next;
  logic [31:0]            pc_plus4;
  logic [31:0]            instr_reg, instr_next;
  logic [31:0]            pc4_reg, pc4_next;
  logic                   valid_reg, valid_next;
  logic [COUNT_WIDTH-1:0] count_reg, count_next;

  // Wraps naturally modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
  assign pc_plus4 = pc_reg + 32'd4;

  // Redirect outranks stall: a flushed bubble never needs to be held, and
  // the branch outcome must not be lost while decode is stalled.
  always_comb begin
    mode = MODE_RUN;
    if (redirect) begin
      mode = MODE_FLUSH;
    end else if (stall) begin
      mode = MODE_HOLD;
    end
  end

  always_comb begin
    pc_next    = pc_reg;
    instr_next = instr_reg;
    pc4_next   = pc4_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    case (mode)
      MODE_RUN: begin
        // Memory is combinational, so the word at pc is captured on the
        // same edge that advances pc.
        pc_next    = pc_plus4;
        instr_next = instr_data;
        pc4_next   = pc_plus4;
        valid_next = 1'b1;
        count_next = count_reg + COUNT_WIDTH'(1);
      end
      MODE_FLUSH: begin
        // Masking (rather than slicing) keeps every target bit in use and
        // guarantees a word-aligned PC.
        pc_next    = redirect_target & WORD_MASK;
        instr_next = 32'd0;
        pc4_next   = 32'd0;
        valid_next = 1'b0;
      end
      MODE_HOLD: begin
        // Everything already holds via the defaults.
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_reg    <= RESET_PC & WORD_MASK;
      instr_reg <= 32'd0;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      pc4_reg   <= pc4_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  assign address        = pc_reg;
  assign if_id_instr    = instr_reg;
  assign if_id_pc_plus4 = pc4_reg;
  assign if_id_valid    = valid_reg;
  assign fetch_count    = count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. A behavioural InstructionMemory
// (four preloaded words at 0x0..0xC, a hash of the address elsewhere) feeds
// instr_data from the DUT's address. Directed scenarios use hand-derived
// expected values; the random scenario compares against a small reference
// model of the fetch rules kept in plain variables.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int          CW       = 4;   // small so the counter wrap is exercised
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk;
  logic          reset_n;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_target;
  logic [31:0]   instr_data;
  logic [31:0]   address;
  logic [31:0]   if_id_instr;
  logic [31:0]   if_id_pc_plus4;
  logic          if_id_valid;
  logic [CW-1:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  int          m_count;

  typedef struct {
    bit          rn;
    bit          st;
    bit          rd;
    logic [31:0] tg;
    logic [31:0] a;
    logic [31:0] i;
    logic [31:0] p4;
    logic        v;
    int          c;
  } vec_t;

  instruction_fetch #(
    .RESET_PC   (RESET_PC),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .instr_data     (instr_data),
    .address        (address),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] prog [4];
    prog[0] = 32'h0043_0800;
    prog[1] = 32'h00A6_2000;
    prog[2] = 32'h0109_3800;
    prog[3] = 32'h016C_5000;
    if (a < 32'd16) return prog[a[3:2]];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always_comb instr_data = mem_word(address);

  // Drive one cycle of inputs, let one edge pass, advance the model.
  task automatic step(input bit rn, input bit st, input bit rd, input logic [31:0] tg);
    logic [31:0] fetched;
    reset_n         = rn;
    stall           = st;
    redirect        = rd;
    redirect_target = tg;
    fetched         = mem_word(m_pc);
    @(posedge clk);
    #1;
    if (!rn) begin
      m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0;
    end else if (rd) begin
      m_pc = {tg[31:2], 2'b00}; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (!st) begin
      m_instr = fetched; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      m_valid = 1; m_count = (m_count + 1) % (1 << CW);
    end
  endtask

  task automatic run_table(input string name, input vec_t v[$]);
    foreach (v[k]) begin
      step(v[k].rn, v[k].st, v[k].rd, v[k].tg);
      checks++;
      if (address !== v[k].a) begin
        failures++; $display("FAIL %s[%0d] address got=%h exp=%h", name, k, address, v[k].a);
      end
      checks++;
      if (if_id_instr !== v[k].i) begin
        failures++; $display("FAIL %s[%0d] if_id_instr got=%h exp=%h", name, k, if_id_instr, v[k].i);
      end
      checks++;
      if (if_id_pc_plus4 !== v[k].p4) begin
        failures++; $display("FAIL %s[%0d] if_id_pc_plus4 got=%h exp=%h", name, k, if_id_pc_plus4, v[k].p4);
      end
      checks++;
      if (if_id_valid !== v[k].v) begin
        failures++; $display("FAIL %s[%0d] if_id_valid got=%b exp=%b", name, k, if_id_valid, v[k].v);
      end
      checks++;
      if (fetch_count !== v[k].c[CW-1:0]) begin
        failures++; $display("FAIL %s[%0d] fetch_count got=%0d exp=%0d", name, k, fetch_count, v[k].c);
      end
      $display("%s[%0d] rn=%b st=%b rd=%b tg=%h -> addr=%h instr=%h pc4=%h v=%b cnt=%0d",
               name, k, v[k].rn, v[k].st, v[k].rd, v[k].tg,
               address, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count);
    end
  endtask

  task automatic test_reset();
    vec_t v[$];
    v.push_back('{0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0});
    run_table("reset", v);
  endtask

  // Four sequential fetches from the preloaded program.
  task automatic test_sequential_fetch();
    vec_t v[$];
    v.push_back('{1, 0, 0, 32'h0, 32'h4,  32'h0043_0800, 32'h4,  1'b1, 1});
    v.push_back('{1, 0, 0, 32'h0, 32'h8,  32'h00A6_2000, 32'h8,  1'b1, 2});
    v.push_back('{1, 0, 0, 32'h0, 32'hC,  32'h0109_3800, 32'hC,  1'b1, 3});
    v.push_back('{1, 0, 0, 32'h0, 32'h10, 32'h016C_5000, 32'h10, 1'b1, 4});
    run_table("seq", v);
  endtask

  // Stall three cycles at pc=8, then release.
  task automatic test_stall();
    vec_t v[$];
    v.push_back('{0, 0, 0, 32'h0, 32'h0, 32'h0,          32'h0, 1'b0, 0});
    v.push_back('{1, 0, 0, 32'h0, 32'h4, 32'h0043_0800, 32'h4, 1'b1, 1});
    v.push_back('{1, 0, 0, 32'h0, 32'h8, 32'h00A6_2000, 32'h8, 1'b1, 2});
    v.push_back('{1, 1, 0, 32'h0, 32'h8, 32'h00A6_2000, 32'h8, 1'b1, 2});
    v.push_back('{1, 1, 0, 32'h0, 32'h8, 32'h00A6_2000, 32'h8, 1'b1, 2});
    v.push_back('{1, 1, 0, 32'h0, 32'h8, 32'h00A6_2000, 32'h8, 1'b1, 2});
    v.push_back('{1, 0, 0, 32'h0, 32'hC, 32'h0109_3800, 32'hC, 1'b1, 3});
    run_table("stall", v);
  endtask

  // From pc=C: redirect to 7 (aligned to 4), then fetch from the target;
  // then back-to-back redirects.
  task automatic test_redirect();
    vec_t v[$];
    v.push_back('{1, 0, 1, 32'h7,  32'h4,  32'h0,          32'h0, 1'b0, 3});
    v.push_back('{1, 0, 0, 32'h0,  32'h8,  32'h00A6_2000, 32'h8, 1'b1, 4});
    v.push_back('{1, 0, 1, 32'h22, 32'h20, 32'h0,          32'h0, 1'b0, 4});
    v.push_back('{1, 0, 1, 32'hD,  32'hC,  32'h0,          32'h0, 1'b0, 4});
    v.push_back('{1, 0, 0, 32'h0,  32'h10, 32'h016C_5000, 32'h10, 1'b1, 5});
    run_table("redirect", v);
  endtask

  // Redirect and stall together: redirect wins, IF/ID flushed.
  task automatic test_stall_redirect();
    vec_t v[$];
    v.push_back('{1, 1, 1, 32'h0, 32'h0, 32'h0,          32'h0, 1'b0, 5});
    v.push_back('{1, 0, 0, 32'h0, 32'h4, 32'h0043_0800, 32'h4, 1'b1, 6});
    run_table("stall_redirect", v);
  endtask

  // PC wrap from FFFF_FFFC to 0.
  task automatic test_wrap();
    vec_t v[$];
    v.push_back('{1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 6});
    v.push_back('{1, 0, 0, 32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1, 7});
    run_table("wrap", v);
  endtask

  // Reset during a stall (pc=8, count=2) and during a redirect.
  task automatic test_reset_during_stall();
    vec_t v[$];
    v.push_back('{0, 0, 0, 32'h0,  32'h0, 32'h0,          32'h0, 1'b0, 0});
    v.push_back('{1, 0, 0, 32'h0,  32'h4, 32'h0043_0800, 32'h4, 1'b1, 1});
    v.push_back('{1, 0, 0, 32'h0,  32'h8, 32'h00A6_2000, 32'h8, 1'b1, 2});
    v.push_back('{0, 1, 0, 32'h0,  32'h0, 32'h0,          32'h0, 1'b0, 0});
    v.push_back('{1, 0, 0, 32'h0,  32'h4, 32'h0043_0800, 32'h4, 1'b1, 1});
    v.push_back('{0, 1, 1, 32'h40, 32'h0, 32'h0,          32'h0, 1'b0, 0});
    run_table("reset_stall", v);
  endtask

  // Randomized mix checked against the reference model; with CW=4 the
  // counter wraps several times.
  task automatic test_random();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      bit          rn, st, rd;
      logic [31:0] tg;
      rn = ($urandom_range(0, 59) != 0);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 6) == 0);
      tg = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 63)) : 32'($urandom);
      step(rn, st, rd, tg);
      checks++;
      if (address !== m_pc || if_id_instr !== m_instr || if_id_pc_plus4 !== m_pc4 ||
          if_id_valid !== m_valid || fetch_count !== m_count[CW-1:0]) begin
        failures++;
        $display("FAIL random[%0d] got addr=%h instr=%h pc4=%h v=%b cnt=%0d exp addr=%h instr=%h pc4=%h v=%b cnt=%0d",
                 n, address, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count,
                 m_pc, m_instr, m_pc4, m_valid, m_count);
      end
      $display("random[%0d] rn=%b st=%b rd=%b tg=%h -> addr=%h instr=%h v=%b cnt=%0d",
               n, rn, st, rd, tg, address, if_id_instr, if_id_valid, fetch_count);
    end
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0;
    test_reset();
    test_sequential_fetch();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_wrap();
    test_reset_during_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
